tvm_linebuf_writer: RTL and testbench
=====================================

# tvm_linebuf_writer

Producer-side companion to `tvm_buffer` for line-buffered convolution. It accepts a raster-order pixel stream from an upstream valid/ready source and drives the buffer's write port one pixel per beat. It tracks row and column position and checks frame framing. It sits between the image source and `tvm_buffer`, opposite the window-address reader on the read port.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- IMAGE_WIDTH, 8, pixels per row
- IMAGE_HEIGHT, 8, rows per frame
- COORD_WIDTH, 4, width of row/col counters (must hold IMAGE_WIDTH-1 and IMAGE_HEIGHT-1)
- WR_ADDR_WIDTH, 1, width of buffer write address
- FLUSH_COUNT, 11, zero pixels appended per frame when flush is compiled in; default (KERNEL_WIDTH-1)*IMAGE_WIDTH-KERNEL_WIDTH+... sized for a 3x3 kernel on 8-wide rows

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  DATA_WIDTH  upstream pixel
- in_valid  in  1  upstream pixel valid
- in_last  in  1  upstream marks final pixel of frame
- in_ready  out  1  writer can accept a pixel
- write_data  out  DATA_WIDTH  to buffer write_data
- write_valid  out  1  to buffer write_valid
- write_advance  out  1  to buffer write_advance
- write_addr  out  WR_ADDR_WIDTH  to buffer write_addr, constant 0
- write_ready  in  1  from buffer write_ready
- col  out  COORD_WIDTH  column of next pixel to be accepted
- row  out  COORD_WIDTH  row of next pixel to be accepted
- frame_done  out  1  one-cycle pulse when a frame's final write beat (including flush) completes
- err_framing  out  1  sticky framing error

## Operation
- Reset (rst_n=0 at a clock edge): write_valid=0, write_advance=0, write_data=0, write_addr=0, in_ready=0, col=0, row=0, frame_done=0, err_framing=0, state=STREAM. in_ready goes to 1 the cycle after rst_n returns high. A reset mid-frame discards the held pixel and any pending flush.
- Input beat: in_valid && in_ready. Output beat: write_valid && write_ready.
- Output stage is a single holding register. in_ready = (state==STREAM) && (!write_valid || write_ready).
- An input beat loads write_data and sets write_valid. write_advance equals write_valid on every cycle; each written pixel advances the buffer by one. write_valid clears after an output beat unless a new input beat loads the register in the same cycle.
- Counters advance on input beats. col increments and wraps from IMAGE_WIDTH-1 to 0. When col wraps, row increments. row wraps from IMAGE_HEIGHT-1 to 0 at frame end.
- Framing check: in_last must be 1 exactly on the beat where col==IMAGE_WIDTH-1 and row==IMAGE_HEIGHT-1. Any mismatch sets err_framing, which clears only on reset. On a mismatch the counters still follow the geometry, and in_last is ignored for frame end.
- States:
  - STREAM: accepts pixels. The frame-final input beat goes to FLUSH if the flush feature is compiled in, otherwise it stays in STREAM.
  - FLUSH: in_ready=0. Emits FLUSH_COUNT beats of write_data=0 through the same register and handshake. After the last flush output beat it returns to STREAM.
- frame_done pulses on the cycle after the output beat of the frame's last write: the last pixel, or the last flush zero when flush is compiled in.

## Timing
- Latency: an input beat at edge N gives write_valid=1 from N until its output beat; the data is visible the cycle after acceptance.
- Throughput is 1 pixel/cycle while write_ready=1. Back-to-back beats are allowed when an output beat and an input beat happen in the same cycle.
- write_ready low holds write_data and write_valid stable and drops in_ready combinationally.
- When FLUSH_COUNT=0 with the flush feature compiled in, FLUSH is skipped.

## Configuration
- TVM_LINEBUF_FLUSH_EN defined: the FLUSH state exists, and FLUSH_COUNT zeros follow each frame so the reader can drain the final windows. frame_done follows the last zero.
- Not defined: no FLUSH state and the FLUSH_COUNT parameter is unused. frame_done follows the last real pixel, and the writer accepts the next frame immediately.

## Test plan
- Frame of 64 pixels 0..63, write_ready=1, in_last on pixel 63: 64 write beats with data 0..63 in order. write_advance=1 on each beat. row/col return to 0/0. One frame_done pulse; err_framing=0.
- Same frame with write_ready toggling 1,0 every cycle: write_data is held through each low cycle, no pixel is lost or duplicated, and in_ready=0 whenever write_valid=1 && write_ready=0.
- in_last asserted on pixel 40: err_framing=1 from the next cycle and stays 1 until rst_n=0. The counters still wrap at pixel 63.
- With TVM_LINEBUF_FLUSH_EN: after pixel 63, exactly 11 beats with write_data=0 and in_ready=0 throughout, frame_done after the 11th beat, then in_ready=1.
- rst_n=0 at pixel 20 with write_valid=1: next cycle write_valid=0, row=0, col=0, frame_done=0. A following full frame completes normally.

Source files
------------

// File: rtl/tvm_linebuf_writer_if.sv
// Stream-in / buffer-write bundle for tvm_linebuf_writer.
// The master modport is the writer's view: it consumes the upstream pixel
// stream and drives the write port of tvm_buffer. The slave modport is the
// view of the surrounding logic (pixel source plus buffer write port).
interface tvm_linebuf_writer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int WR_ADDR_WIDTH = 1
);
    // Upstream raster pixel stream
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;

    // Buffer write port
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     write_valid;
    logic                     write_advance;
    logic [WR_ADDR_WIDTH-1:0] write_addr;
    logic                     write_ready;

    modport master (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output write_data,
        output write_valid,
        output write_advance,
        output write_addr,
        input  write_ready
    );

    modport slave (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  write_data,
        input  write_valid,
        input  write_advance,
        input  write_addr,
        output write_ready
    );
endinterface

// File: rtl/tvm_linebuf_writer.sv
// tvm_linebuf_writer: producer side of the line buffer. Accepts a raster
// pixel stream, forwards one pixel per beat to the buffer write port through
// a single holding register, tracks row/col and flags framing errors.
// Optional feature macro: TVM_LINEBUF_FLUSH_EN -- when defined, FLUSH_COUNT
// zero pixels are written after each frame so the reader can drain its final
// windows; when undefined the FLUSH state does not exist.
module tvm_linebuf_writer #(
    parameter int DATA_WIDTH    = 8,
    parameter int IMAGE_WIDTH   = 8,
    parameter int IMAGE_HEIGHT  = 8,
    parameter int COORD_WIDTH   = 4,
    parameter int WR_ADDR_WIDTH = 1,
    parameter int FLUSH_COUNT   = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tvm_linebuf_writer_if.master   bus,
    output logic [COORD_WIDTH-1:0] col,
    output logic [COORD_WIDTH-1:0] row,
    output logic                   frame_done,
    output logic                   err_framing
);

    localparam logic [COORD_WIDTH-1:0] COL_MAX = COORD_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] ROW_MAX = COORD_WIDTH'(IMAGE_HEIGHT - 1);

`ifdef TVM_LINEBUF_FLUSH_EN
    typedef enum logic {ST_STREAM, ST_FLUSH} state_t;

    // Zero-width counters are illegal, so keep at least one bit when flush is empty
    localparam int FLUSH_CW = (FLUSH_COUNT > 0) ? $clog2(FLUSH_COUNT + 1) : 1;

    logic [FLUSH_CW-1:0] flush_left;
    logic                flush_load;
`else
    typedef enum logic {ST_STREAM} state_t;

    // FLUSH_COUNT only matters when the flush tail is built in
    logic unused_flush;
    assign unused_flush = ^FLUSH_COUNT;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  last_p1;   // held word is the final write of a frame
    logic                  rdy_en;    // keeps in_ready low for the first cycle out of reset
    logic                  at_end;
    logic                  reg_free;
    logic                  in_ready_c;
    logic                  in_beat;
    logic                  out_beat;

    assign at_end     = (col == COL_MAX) && (row == ROW_MAX);
    assign reg_free   = !vld_p1 || bus.write_ready;
    assign in_ready_c = rdy_en && (state == ST_STREAM) && reg_free;
    assign in_beat    = bus.in_valid && in_ready_c;
    assign out_beat   = vld_p1 && bus.write_ready;

`ifdef TVM_LINEBUF_FLUSH_EN
    assign flush_load = (state == ST_FLUSH) && (flush_left != '0) && reg_free;
`endif

    assign bus.in_ready      = in_ready_c;
    assign bus.write_data    = data_p1;
    assign bus.write_valid   = vld_p1;
    assign bus.write_advance = vld_p1;
    assign bus.write_addr    = {WR_ADDR_WIDTH{1'b0}};

    // Holding register, raster counters, framing check and flush sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_STREAM;
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            rdy_en      <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_done  <= 1'b0;
            err_framing <= 1'b0;
`ifdef TVM_LINEBUF_FLUSH_EN
            flush_left  <= '0;
`endif
        end else begin
            rdy_en     <= 1'b1;
            frame_done <= out_beat && last_p1;

            if (in_beat) begin
                data_p1 <= bus.in_data;
                vld_p1  <= 1'b1;

                // Frame end follows the geometry; in_last only feeds the error flag
                if (bus.in_last != at_end) begin
                    err_framing <= 1'b1;
                end

                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

`ifdef TVM_LINEBUF_FLUSH_EN
                if (at_end && (FLUSH_COUNT != 0)) begin
                    state      <= ST_FLUSH;
                    flush_left <= FLUSH_CW'(FLUSH_COUNT);
                    last_p1    <= 1'b0;
                end else begin
                    last_p1    <= at_end;
                end
`else
                last_p1 <= at_end;
`endif
            end
`ifdef TVM_LINEBUF_FLUSH_EN
            else if (flush_load) begin
                data_p1    <= '0;
                vld_p1     <= 1'b1;
                flush_left <= flush_left - 1'b1;
                last_p1    <= (flush_left == FLUSH_CW'(1));
            end
`endif
            else if (out_beat) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end

`ifdef TVM_LINEBUF_FLUSH_EN
            // Leave FLUSH once the last zero has actually been taken by the buffer
            if ((state == ST_FLUSH) && (flush_left == '0) && out_beat) begin
                state <= ST_STREAM;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tvm_linebuf_writer.sv
// Directed bench for tvm_linebuf_writer with a scoreboard queue of expected
// write-port words. Follows TVM_LINEBUF_FLUSH_EN so it matches either build.
module tb_tvm_linebuf_writer;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int CW = 4;
    localparam int AW = 1;
    localparam int FC = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          frame_done;
    logic          err_framing;

    tvm_linebuf_writer_if #(.DATA_WIDTH(DW), .WR_ADDR_WIDTH(AW)) bus ();

    tvm_linebuf_writer #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .COORD_WIDTH(CW), .WR_ADDR_WIDTH(AW), .FLUSH_COUNT(FC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .col(col),
        .row(row),
        .frame_done(frame_done),
        .err_framing(err_framing)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            fd_count = 0;
    logic [DW-1:0] exp_q[$];
    bit            toggle = 1'b0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every write beat
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_data", bus.write_data, hold_data);
                chk("hold_valid", bus.write_valid, 1);
            end
            if (bus.write_valid && !bus.write_ready) begin
                chk("inrdy_stall", bus.in_ready, 0);
            end
            if (bus.write_valid && bus.write_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_extra observed %0h expected none", bus.write_data);
                end else begin
                    chk("wdata", bus.write_data, exp_q.pop_front());
                    chk("wadv", bus.write_advance, 1);
                end
            end
            if (frame_done) fd_count++;
            hold_prev = bus.write_valid && !bus.write_ready;
            hold_data = bus.write_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle) bus.write_ready = ~bus.write_ready;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        bit acc = 1'b0;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) exp_q.push_back(d);
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed no accept expected accept of %0h", d);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int last_idx);
        for (int i = lo; i <= hi; i++) begin
            send(DW'(i), i == last_idx);
            if (i == 10) begin
                chk("row_mid", row, 1);
                chk("col_mid", col, 3);
            end
`ifdef TVM_LINEBUF_FLUSH_EN
            if (i == IW * IH - 1) begin
                for (int k = 0; k < FC; k++) exp_q.push_back('0);
            end
`endif
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.write_valid) && n < 500) begin
`ifdef TVM_LINEBUF_FLUSH_EN
            if (exp_q.size() != 0) chk("flush_inrdy", bus.in_ready, 0);
`endif
            step();
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed %0d pending expected 0", exp_q.size());
        end
        step();
        step();
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.write_ready = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_wvalid", bus.write_valid, 0);
        chk("rst_wadv", bus.write_advance, 0);
        chk("rst_wdata", bus.write_data, 0);
        chk("rst_waddr", bus.write_addr, 0);
        chk("rst_inrdy", bus.in_ready, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_err", err_framing, 0);

        rst_n = 1'b1;
        step();
        chk("rel_inrdy", bus.in_ready, 1);

        // Frame 1: clean frame, buffer always ready
        send_range(0, 63, 63);
        drain();
        chk("f1_row", row, 0);
        chk("f1_col", col, 0);
        chk("f1_fdone", fd_count, 1);
        chk("f1_err", err_framing, 0);
        chk("f1_inrdy", bus.in_ready, 1);

        // Frame 2: buffer ready toggling every cycle
        toggle = 1'b1;
        send_range(0, 63, 63);
        drain();
        toggle = 1'b0;
        bus.write_ready = 1'b1;
        chk("f2_row", row, 0);
        chk("f2_col", col, 0);
        chk("f2_fdone", fd_count, 2);
        chk("f2_err", err_framing, 0);

        // Frame 3: in_last on pixel 40 instead of 63
        send_range(0, 39, -1);
        chk("f3_err_pre", err_framing, 0);
        send_range(40, 40, 40);
        chk("f3_err_set", err_framing, 1);
        send_range(41, 63, -1);
        drain();
        chk("f3_err_sticky", err_framing, 1);
        chk("f3_row", row, 0);
        chk("f3_col", col, 0);
        chk("f3_fdone", fd_count, 3);

        // Reset in the middle of a frame with a pixel held
        send_range(0, 20, -1);
        bus.write_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_wvalid_pre", bus.write_valid, 1);
        exp_q.delete();
        step();
        chk("mid_wvalid", bus.write_valid, 0);
        chk("mid_row", row, 0);
        chk("mid_col", col, 0);
        chk("mid_fdone", frame_done, 0);
        chk("mid_err", err_framing, 0);
        chk("mid_inrdy", bus.in_ready, 0);
        rst_n = 1'b1;
        bus.write_ready = 1'b1;
        step();
        chk("mid_inrdy_rel", bus.in_ready, 1);

        // Frame 4: full frame after the mid-frame reset
        send_range(0, 63, 63);
        drain();
        chk("f4_row", row, 0);
        chk("f4_col", col, 0);
        chk("f4_fdone", fd_count, 4);
        chk("f4_err", err_framing, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
